regbank_sequencer: RTL

//  Command-driven controller for the 8x8 register bank (X0 hard-wired zero, 2 comb read ports, 1 sync write port).

---
 rtl/regbank_seq_pkg.sv | 25 ++
 rtl/regbank_seq_alu.sv | 27 ++
 rtl/regbank_sequencer.sv | 125 ++++++++++++
 3 files changed

// File: rtl/regbank_seq_pkg.sv
// Shared types and default widths for the register-bank command sequencer.
package regbank_seq_pkg;

    localparam int unsigned DATA_W_DEF = 8;
    localparam int unsigned ADDR_W_DEF = 3;

    typedef enum logic [2:0] {
        OpLdi = 3'b000,
        OpMov = 3'b001,
        OpAdd = 3'b010,
        OpSub = 3'b011,
        OpAnd = 3'b100,
        OpOr  = 3'b101,
        OpRd  = 3'b110,
        OpClr = 3'b111
    } op_e;

    typedef enum logic [1:0] {
        StIdle  = 2'b00,
        StExec  = 2'b01,
        StWrite = 2'b10,
        StClear = 2'b11
    } state_e;

endpackage

// File: rtl/regbank_seq_alu.sv
// Combinational result unit: maps opcode and operands to the value written back or returned.
module regbank_seq_alu
    import regbank_seq_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF
) (
    input  op_e               op,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic [DATA_W-1:0] imm,
    output logic [DATA_W-1:0] result
);

    always_comb begin
        result = '0;
        unique case (op)
            OpLdi:        result = imm;
            OpMov, OpRd:  result = a;
            OpAdd:        result = a + b;
            OpSub:        result = a - b;
            OpAnd:        result = a & b;
            OpOr:         result = a | b;
            OpClr:        result = '0;
        endcase
    end

endmodule

// File: rtl/regbank_sequencer.sv
// Command sequencer owning the register bank ports: read, compute, write back or respond,
// plus a bulk clear sweep of X1..X(N-1).
module regbank_sequencer
    import regbank_seq_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned ADDR_W = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [2:0]        cmd_op,
    input  logic [ADDR_W-1:0] cmd_rd,
    input  logic [ADDR_W-1:0] cmd_rs1,
    input  logic [ADDR_W-1:0] cmd_rs2,
    input  logic [DATA_W-1:0] cmd_imm,
    output logic              rf_write_enable,
    output logic [ADDR_W-1:0] rf_write_addr,
    output logic [DATA_W-1:0] rf_write_data,
    output logic [ADDR_W-1:0] rf_reg_addr_1,
    output logic [ADDR_W-1:0] rf_reg_addr_2,
    input  logic [DATA_W-1:0] rf_reg_data_1,
    input  logic [DATA_W-1:0] rf_reg_data_2,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_data,
    output logic              op_done
);

    localparam int unsigned NUM_REGS = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] LAST_ADDR  = ADDR_W'(NUM_REGS - 1);
    localparam logic [ADDR_W-1:0] FIRST_ADDR = ADDR_W'(1);

    state_e            state_q;
    op_e               op_q;
    logic [ADDR_W-1:0] rd_q;
    logic [DATA_W-1:0] imm_q;
    logic [DATA_W-1:0] alu_result;

    regbank_seq_alu #(
        .DATA_W (DATA_W)
    ) u_alu (
        .op     (op_q),
        .a      (rf_reg_data_1),
        .b      (rf_reg_data_2),
        .imm    (imm_q),
        .result (alu_result)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q         <= StIdle;
            op_q            <= OpLdi;
            rd_q            <= '0;
            imm_q           <= '0;
            cmd_ready       <= 1'b1;
            rf_write_enable <= 1'b0;
            rf_write_addr   <= '0;
            rf_write_data   <= '0;
            rf_reg_addr_1   <= '0;
            rf_reg_addr_2   <= '0;
            rsp_valid       <= 1'b0;
            rsp_data        <= '0;
            op_done         <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (cmd_valid) begin
                        op_q          <= op_e'(cmd_op);
                        rd_q          <= cmd_rd;
                        imm_q         <= cmd_imm;
                        rf_reg_addr_1 <= cmd_rs1;
                        rf_reg_addr_2 <= cmd_rs2;
                        cmd_ready     <= 1'b0;
                        if (op_e'(cmd_op) == OpClr) begin
                            // The sweep's first write is issued straight from the handshake.
                            state_q         <= StClear;
                            rf_write_enable <= 1'b1;
                            rf_write_addr   <= FIRST_ADDR;
                            rf_write_data   <= '0;
                            op_done         <= (FIRST_ADDR == LAST_ADDR);
                        end else begin
                            state_q <= StExec;
                        end
                    end
                end
                StExec: begin
                    state_q <= StWrite;
                    op_done <= 1'b1;
                    if (op_q == OpRd) begin
                        rsp_valid <= 1'b1;
                        rsp_data  <= alu_result;
                    end else begin
                        rf_write_enable <= (rd_q != '0);
                        rf_write_addr   <= rd_q;
                        rf_write_data   <= alu_result;
                    end
                end
                StWrite: begin
                    state_q         <= StIdle;
                    cmd_ready       <= 1'b1;
                    rf_write_enable <= 1'b0;
                    rf_write_addr   <= '0;
                    rf_write_data   <= '0;
                    rsp_valid       <= 1'b0;
                    op_done         <= 1'b0;
                end
                StClear: begin
                    if (rf_write_addr == LAST_ADDR) begin
                        state_q         <= StIdle;
                        cmd_ready       <= 1'b1;
                        rf_write_enable <= 1'b0;
                        rf_write_addr   <= '0;
                        op_done         <= 1'b0;
                    end else begin
                        rf_write_addr <= rf_write_addr + FIRST_ADDR;
                        op_done       <= ((rf_write_addr + FIRST_ADDR) == LAST_ADDR);
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule
